// File: rtl/simplebus_rr_arb.sv
// simplebus_rr_arb: round-robin merge of NCH valid/ready channels onto one
// simplebus output through a DEPTH-entry FIFO.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid[NCH]       per-channel request
//   in_data[NCH*WIDTH]  per-channel payload, channel i at [i*WIDTH +: WIDTH]
//   in_ready[NCH]       per-channel accept (one-hot or zero)
//   out_valid/out_ready FIFO head handshake
//   out_data, out_chan  FIFO head payload and source channel
//   count               FIFO occupancy
// Optional (SIMPLEBUS_PARITY_EN defined):
//   in_par[NCH]         even parity over each channel payload
//   out_par             stored parity of FIFO head
//   par_err             sticky, set by a push with bad parity; reset clears

// Per-channel slice: turns the grant into the ready bit and an AND-OR mux leg.
module simplebus_rr_lane #(
  parameter int WIDTH = 8
)(
  input  logic             gnt,
  input  logic             space,
  input  logic [WIDTH-1:0] data,
`ifdef SIMPLEBUS_PARITY_EN
  input  logic             par,
  output logic             perr,
`endif
  output logic             ready,
  output logic [WIDTH-1:0] dsel
);
  assign ready = gnt & space;
  assign dsel  = gnt ? data : '0;
`ifdef SIMPLEBUS_PARITY_EN
  assign perr  = gnt & (par != ^data);
`endif
endmodule

module simplebus_rr_arb #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(NCH),
  localparam int CNTW = $clog2(DEPTH+1)
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
`ifdef SIMPLEBUS_PARITY_EN
  input  logic [NCH-1:0]       in_par,
  output logic                 out_par,
  output logic                 par_err,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic [CNTW-1:0]      count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
`ifdef SIMPLEBUS_PARITY_EN
    logic             par;
`endif
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t                     mem [DEPTH];
  entry_t                     wentry, head;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [CW-1:0]              ptr, win;
  logic                       found, space, space_g, push, pop;
  logic [NCH-1:0]             gnt;
  logic [NCH-1:0][WIDTH-1:0]  dsel;
  logic [WIDTH-1:0]           push_data;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A same-cycle pop frees a slot, so a full FIFO still takes one push.
  assign space     = (count < CNTW'(DEPTH)) | pop;
  // Nothing is granted while reset is held.
  assign space_g   = space & rst_n;

  // Rotating-priority search starting at ptr.
  always_comb begin : arbiter
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_gnt
    assign gnt[i] = found & (win == CW'(i));
  end

`ifdef SIMPLEBUS_PARITY_EN
  logic [NCH-1:0] perr;
`endif

  simplebus_rr_lane #(.WIDTH(WIDTH)) u_lane [NCH-1:0] (
    .gnt   (gnt),
    .space (space_g),
    .data  (in_data),
`ifdef SIMPLEBUS_PARITY_EN
    .par   (in_par),
    .perr  (perr),
`endif
    .ready (in_ready),
    .dsel  (dsel)
  );

  assign push = found & space_g;

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NCH; i++) push_data |= dsel[i];
  end

  always_comb begin
    wentry      = '0;
    wentry.chan = win;
    wentry.data = push_data;
`ifdef SIMPLEBUS_PARITY_EN
    wentry.par  = |(gnt & in_par);
`endif
  end

  // Storage carries no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wentry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ptr    <= (win == CW'(NCH-1)) ? '0 : win + 1'b1;
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign out_data = head.data;
  assign out_chan = head.chan;

`ifdef SIMPLEBUS_PARITY_EN
  assign out_par = head.par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               par_err <= 1'b0;
    else if (push && |perr)   par_err <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= CNTW'(DEPTH));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: tb/tb_simplebus_rr_arb.sv
module tb_simplebus_rr_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic [1:0]  count;
`ifdef SIMPLEBUS_PARITY_EN
  logic [3:0]  in_par = '0;
  logic        out_par;
  logic        par_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simplebus_rr_arb #(.NCH(4), .WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef SIMPLEBUS_PARITY_EN
    .in_par    (in_par),
    .out_par   (out_par),
    .par_err   (par_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .count     (count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    in_data[ch*8 +: 8] = d;
  endtask

  task automatic test_reset();
    in_valid = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got %b exp 0000", in_ready); end
    cyc();
    rst_n = 1'b1;
    in_valid = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle[%0d] got v=%b c=%0d r=%b exp v=0 c=0 r=0000", i, out_valid, count, in_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    cyc();
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        checks++;
        if (in_ready !== 4'(1 << (k % 4))) begin
          errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, in_ready, 4'(1 << (k % 4)));
        end
      end
      if (k > 0) begin
        checks++;
        if (out_chan !== 2'((k-1) % 4) || out_data !== 8'(8'h10 + (k-1) % 4) || count !== 2'd1) begin
          errors++;
          $display("FAIL rr_out[%0d] got ch=%0d d=%h c=%0d exp ch=%0d d=%h c=1", k, out_chan, out_data, count,
                   (k-1) % 4, 8'h10 + (k-1) % 4);
        end
      end
      if (k == 6) in_valid = '0;
    end
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL rr_drain got %0d exp 0", count); end
  endtask

  // ptr is 2 on entry
  task automatic test_full();
    cyc();
    out_ready = 1'b0; in_valid = 4'b0100; set_data(2, 8'hA5);
    @(negedge clk);
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL full_first_ready got %b exp 0100", in_ready); end
    cyc();
    set_data(2, 8'h5A);
    @(negedge clk);
    checks++;
    if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      errors++; $display("FAIL full_latency got c=%0d v=%b d=%h ch=%0d exp c=1 v=1 d=a5 ch=2", count, out_valid, out_data, out_chan);
    end
    cyc();
    @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", count); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL full_noready got %b exp 0000", in_ready); end
    cyc();
    out_ready = 1'b1; set_data(2, 8'h3C);
    @(negedge clk);
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL full_poppush_ready got %b exp 0100", in_ready); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL full_head got %h exp a5", out_data); end
    cyc();
    in_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 2'd2 || out_data !== 8'h5A) begin
      errors++; $display("FAIL full_simul got c=%0d d=%h exp c=2 d=5a", count, out_data);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL full_stable got %h exp 5a", out_data); end
    cyc();
    @(negedge clk);
    checks++;
    if (count !== 2'd1 || out_data !== 8'h3C || out_chan !== 2'd2) begin
      errors++; $display("FAIL full_third got c=%0d d=%h ch=%0d exp c=1 d=3c ch=2", count, out_data, out_chan);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL full_empty got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
  endtask

  // ptr is 3 on entry (last grant was channel 2)
  task automatic test_wrap();
    cyc();
    set_data(1, 8'h11); set_data(3, 8'h33); in_valid = 4'b1010; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", in_ready); end
    cyc();
    @(negedge clk);
    checks++;
    if (out_chan !== 2'd3 || out_data !== 8'h33) begin
      errors++; $display("FAIL wrap_out3 got ch=%0d d=%h exp ch=3 d=33", out_chan, out_data);
    end
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_second got %b exp 0010", in_ready); end
    cyc();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_chan !== 2'd1 || out_data !== 8'h11 || count !== 2'd1) begin
      errors++; $display("FAIL wrap_out1 got ch=%0d d=%h c=%0d exp ch=1 d=11 c=1", out_chan, out_data, count);
    end
    cyc();
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    cyc();
    out_ready = 1'b0; set_data(0, 8'h77); in_valid = 4'b0001;
    cyc();
    set_data(0, 8'h78);
    cyc();
    in_valid = 4'hF;
    @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL mid_fill got %0d exp 2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_async got v=%b c=%0d r=%b exp v=0 c=0 r=0000", out_valid, count, in_ready);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h40 + i));
    @(negedge clk);
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", in_ready); end
    cyc();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h40 || count !== 2'd1) begin
      errors++; $display("FAIL mid_first got v=%b ch=%0d d=%h c=%0d exp v=1 ch=0 d=40 c=1", out_valid, out_chan, out_data, count);
    end
    cyc();
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL mid_drain got %0d exp 0", count); end
  endtask

`ifdef SIMPLEBUS_PARITY_EN
  task automatic test_parity();
    cyc();
    out_ready = 1'b0; set_data(0, 8'h03); in_par = 4'b0001; in_valid = 4'b0001;
    @(negedge clk);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", par_err); end
    cyc();
    in_valid = '0; in_par = '0;
    @(negedge clk);
    checks++;
    if (par_err !== 1'b1 || out_par !== 1'b1 || out_data !== 8'h03) begin
      errors++; $display("FAIL par_set got e=%b p=%b d=%h exp e=1 p=1 d=03", par_err, out_par, out_data);
    end
    cyc();
    out_ready = 1'b1; set_data(0, 8'h05); in_valid = 4'b0001;
    cyc();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (par_err !== 1'b1 || out_par !== 1'b0 || out_data !== 8'h05) begin
      errors++; $display("FAIL par_hold got e=%b p=%b d=%h exp e=1 p=0 d=05", par_err, out_par, out_data);
    end
    cyc();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_full();
    test_wrap();
    test_reset_mid();
`ifdef SIMPLEBUS_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simplebus_rr_arb.md
Name: simplebus_rr_arb

Overview:
- Parametrised successor to the single-modport simplebus: merges NCH independent valid/ready request channels onto one simplebus output.
- Arbitration is round-robin and fair. A DEPTH-entry output FIFO decouples arbitration from the consumer.
- Sits between multiple simplebus producers and a single consumer port in the top-level fabric.

Parameters:
- NCH, 4, number of input channels (>=2)
- WIDTH, 8, payload width per channel (>=1)
- DEPTH, 2, output FIFO entries (>=1)
- CW, $clog2(NCH), channel-index width (derived, not overridden)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NCH  per-channel request; bit i is channel i
- in_data  input  NCH*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NCH  per-channel accept, one-hot or zero
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accept
- out_data  output  WIDTH  FIFO head payload
- out_chan  output  CW  source channel of FIFO head
- count  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, count=0, out_valid=0.
  - Round-robin pointer ptr=0; rd/wr pointers=0.
  - in_ready=0 while reset is asserted.
  - out_data/out_chan are don't-care while out_valid=0.
- Space condition: space = (count<DEPTH) | (out_valid & out_ready).
  - Same-cycle pop frees a slot, so a full FIFO with an accepting consumer still accepts one push.
  - This is a combinational path out_ready -> in_ready.
- Arbitration (combinational, each cycle):
  - Search channels ptr, ptr+1, ..., ptr+NCH-1 (mod NCH). The first with in_valid=1 is the winner w.
  - in_ready[w]=space; all other in_ready bits are 0.
  - If no in_valid bit is set, in_ready=0.
- Push: occurs when in_valid[w] & in_ready[w].
  - FIFO writes {w, in_data[w]}.
  - ptr <= (w+1) mod NCH, wrapping from NCH-1 to 0.
  - ptr is unchanged on cycles without a push.
- Pop: occurs when out_valid & out_ready; the read pointer advances.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointer wrap: rd/wr pointers wrap from DEPTH-1 to 0. Non-power-of-2 DEPTH must work.
- Latency: push at edge N makes the data visible on out_* after edge N (one cycle when the FIFO was empty). There is no combinational in_data -> out_data path.
- Ordering and stability:
  - Output order equals push order.
  - out_data/out_chan stay stable while out_valid=1 and out_ready=0.
- Producer contract: a producer may deassert in_valid without a handshake; the block does not require valid persistence.
- Overflow/underflow: impossible by construction.
  - Simulation assertion: fires if count>DEPTH.
  - Simulation assertion: fires if a pop occurs when count=0.
- Reset mid-operation: all FIFO contents are discarded; out_valid drops asynchronously.

Optional Feature:
- Macro: SIMPLEBUS_PARITY_EN
- Defined:
  - Extra input in_par[NCH]: even parity over that channel's payload.
  - Extra output out_par[1]: stored parity of the FIFO head.
  - Extra output par_err[1], sticky:
    - Set on any push where in_par[w] != ^in_data[w].
    - Cleared only by reset.
    - The offending entry is still pushed unchanged.
  - FIFO width grows by one bit.
- Undefined: these ports and the logic behind them are absent; the port list is exactly as above.

Test Plan:
- Reset, then all in_valid=0 -> out_valid=0, count=0, in_ready=0 for 10 cycles.
- NCH=4, all in_valid=1 continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 with one grant per cycle; count stays at 1 after the first push.
- DEPTH=2, out_ready=0, channel 2 valid with data 0xA5 then 0x5A -> count goes 1,2; in_ready[2]=0 thereafter. Then out_ready=1 for one cycle -> out_data=0xA5 popped, a third item pushed in the same cycle, count stays 2.
- ptr=3 after a grant to channel 2; only channels 1 and 3 valid -> channel 3 granted first, then channel 1 (wrap check).
- Reset asserted with count=2 mid-transfer -> out_valid=0 immediately; after release, the first push from channel 0 appears with out_chan=0.
- With SIMPLEBUS_PARITY_EN: push data 0x03 with in_par=1 -> par_err=1 on the next cycle and held; the entry is still delivered with out_par=1.
